// File: rtl/invaes_core_ctrl.sv
// Iterative AES-128 decryption sequencer: synchronizes the load strobe, expands the key into
// 11 round keys, then replays rk[9]..rk[0] through an external combinational inverse round.
module invaes_core_ctrl #(
  parameter int NR = 10,
  parameter int K  = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [K-1:0] key,
  input  logic [K-1:0] cyphertext,
  output logic [31:0]  sw_in,
  input  logic [31:0]  sw_out,
  output logic [K-1:0] ir_state,
  output logic [K-1:0] ir_key,
  output logic         ir_last,
  input  logic [K-1:0] ir_out,
  output logic [K-1:0] plaintext,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPAND,
    S_INIT,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state, state_next;
  logic         load_q1, load_s, load_d;
  logic [1:0]   sync_fill;
  logic         armed;
  logic         fall;
  logic [K-1:0] st;
  logic [3:0]   cnt;
  logic [K-1:0] rk [NR+1];
  logic [K-1:0] rk_prev, rk_next;
  logic [31:0]  t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // The chain resets to 1, so a fall is only honoured once a genuine high has been sampled;
  // otherwise a load held low through reset would look like a fresh 1->0 edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q1   <= 1'b1;
      load_s    <= 1'b1;
      load_d    <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      load_q1   <= load;
      load_s    <= load_q1;
      load_d    <= load_s;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && load_s) armed <= 1'b1;
    end
  end

  assign fall = armed & load_d & ~load_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (fall) state_next = S_EXPAND;
      S_EXPAND: if (load_s) state_next = S_IDLE;
                else if (cnt == LAST_RND) state_next = S_INIT;
      S_INIT:   state_next = load_s ? S_IDLE : S_ROUND;
      S_ROUND:  if (load_s) state_next = S_IDLE;
                else if (cnt == 4'd0) state_next = S_DONE;
      S_DONE:   if (load_s) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Key schedule step: rk[cnt] from rk[cnt-1] and the S-box result of RotWord(w3).
  always_comb begin
    rk_prev = rk[cnt - 4'd1];
    t       = sw_out ^ {rcon(cnt), 24'h0};
    rk_next[127:96] = rk_prev[127:96] ^ t;
    rk_next[95:64]  = rk_prev[95:64] ^ rk_next[127:96];
    rk_next[63:32]  = rk_prev[63:32] ^ rk_next[95:64];
    rk_next[31:0]   = rk_prev[31:0]  ^ rk_next[63:32];
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    sw_in    = '0;
    ir_state = '0;
    ir_key   = '0;
    ir_last  = 1'b0;
    case (state)
      S_EXPAND: sw_in = {rk_prev[23:0], rk_prev[31:24]};
      S_ROUND: begin
        ir_state = st;
        ir_key   = rk[cnt];
        ir_last  = (cnt == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= '0;
      cnt       <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (fall) begin
          st  <= cyphertext;
          cnt <= 4'd1;
        end
        S_EXPAND: if (!load_s && cnt != LAST_RND) cnt <= cnt + 4'd1;
        S_INIT: if (!load_s) begin
          st  <= st ^ rk[NR];
          cnt <= LAST_RND - 4'd1;
        end
        S_ROUND: if (!load_s) begin
          st <= ir_out;
          if (cnt == 4'd0) begin
            plaintext <= ir_out;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: if (load_s) done <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: round-key storage has no reset; it is always rewritten before being read.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && fall)            rk[0]   <= key;
    else if (state == S_EXPAND && !load_s) rk[cnt] <= rk_next;
  end

endmodule

// File: doc/invaes_core_ctrl.md
Name: invaes_core_ctrl

Overview:
Iterative AES-128 decryption sequencer on the system clock. It sits directly downstream of the SPI shifter, which supplies key[127:0] and cyphertext[127:0], and directly upstream of it, since it returns plaintext[127:0] and done. It synchronizes the master's load strobe, expands the key into 11 round keys, and replays them in reverse through an external combinational inverse-round unit. It also drives an external shared S-box for SubWord.

Parameters:
NR, 10, number of rounds; fixed at 10 for K=128.
K, 128, key width; only 128 supported.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
load  input  1  from master, asynchronous to clk; high while SPI loading
key  input  128  key from SPI block; w0 = key[127:96]
cyphertext  input  128  ciphertext from SPI block
sw_in  output  32  word to external S-box (4 parallel bytes)
sw_out  input  32  S-box result, combinational same cycle
ir_state  output  128  state to external inverse round
ir_key  output  128  round key for the inverse round
ir_last  output  1  1 = final round (skip InvMixColumns)
ir_out  input  128  inverse-round result, combinational same cycle
plaintext  output  128  decrypted block, held while done=1
done  output  1  decryption complete

Behaviour:
- Reset (async assert, sync release): state=IDLE; done=0; plaintext=0; st=0; round counter=0; load sync flops=1. sw_in, ir_state, ir_key and ir_last are 0 outside their active states.
- Synchronization: load passes through 2 flops to produce load_s, plus 1 delay flop load_d. fall = load_d & ~load_s.
- IDLE: on fall, capture rk[0]=key and st=cyphertext, set i=1, go EXPAND.
- EXPAND, i=1..10, one round key per cycle:
  - sw_in = RotWord(w3) = {w3[23:0], w3[31:24]}, where w3 is the last word of rk[i-1].
  - t = sw_out ^ {rcon[i], 24'h0}, with rcon = 01,02,04,08,10,20,40,80,1B,36.
  - rk[i] = {w0^t, w1^w0^t, w2^w1^w0^t, w3^w2^w1^w0^t}.
  - After i=10, go INIT.
- INIT: st <= st ^ rk[10]; r=9; go ROUND.
- ROUND, r=9 down to 0:
  - ir_state=st, ir_key=rk[r], ir_last=(r==0); st <= ir_out.
  - After r=0, go DONE.
- DONE (entry cycle): plaintext <= st; done=1. Hold both until load_s=1, then return to IDLE. done=0 from the next edge. plaintext keeps its value until the next DONE entry.
- Latency: done rises 22 clk edges after the edge that registers fall (1 capture, 10 expand, 1 init, 10 rounds). Add 2-3 clk for synchronization from the raw load edge.
- Abort: load_s=1 in any non-IDLE state forces IDLE next edge. done stays 0 and plaintext is unchanged.
- A new fall in DONE only occurs after load_s has been high, which already returns the block to IDLE. There is no re-trigger without a load pulse.
- plaintext must not change while done=1, because the SPI block samples it on its own clock.
- Round-key storage: 11x128 registers, written only in IDLE capture and EXPAND.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, cyphertext 69c4e0d86a7b0430d8cdb78070b4c55a, load pulse 1->0 -> plaintext 00112233445566778899aabbccddeeff; done=1 exactly 22 edges after fall is registered. The bench supplies behavioural S-box and inverse-round models.
- Key expansion: key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; ir_key=rk[10] is never presented to the round unit; ir_key sequence = rk[9]..rk[0] with ir_last=1 only for rk[0].
- Handshake: after done=1, raise load -> done=0 within 3 clk while plaintext holds its value; drop load with a new key/ct -> second correct result.
- Abort: raise load 5 cycles into ROUND -> state IDLE, done stays 0, plaintext unchanged from the previous result.
- Async reset asserted mid-EXPAND -> done=0 and plaintext=0 immediately; after release the block ignores a steady-low load and only starts on a fresh 1->0 edge.
- Back-to-back: two vectors with load pulses 1 clk wide (>=3 clk after sync) -> both decrypt correctly, and done never asserts during the second run's loading.
